stall_ctrl: RTL and testbench

//  Pipeline hazard/stall controller for the 5-stage CPU. Decides each cycle whether F_PC and the
//  D-stage register hold (stall) and whether a bubble is injected into the E-stage register.

---
 rtl/cpu_defs.sv | 17 +
 rtl/md_busy_counter.sv | 36 +++
 rtl/stall_ctrl.sv | 38 +++
 tb/tb_stall_ctrl.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// cpu_defs: shared pipeline widths, Tuse/Tnew encoding and the per-operand hazard test
package cpu_defs;
  localparam int REG_W = 5;
  localparam int T_W = 2;
  localparam int MD_CNT_W = 4;
  localparam logic [T_W-1:0] TUSE_NEVER = 2'd3;
  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES = 10;
  function automatic logic src_haz(
    input logic [REG_W-1:0] src,
    input logic [T_W-1:0] tuse,
    input logic [REG_W-1:0] dst,
    input logic [T_W-1:0] tnew
  );
    return (src != '0) && (src == dst) && (tuse != TUSE_NEVER) && (tnew > tuse);
  endfunction
endpackage

// File: rtl/md_busy_counter.sv
// md_busy_counter: mult/div busy countdown with sticky error on overlapping issue
module md_busy_counter
  import cpu_defs::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES = DEF_DIV_CYCLES
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                is_div,
  output logic                busy,
  output logic [MD_CNT_W-1:0] cnt,
  output logic                err
);
  logic [MD_CNT_W-1:0] cnt_d, cnt_q;
  logic                err_d, err_q;
  logic                idle;
  always_comb begin
    idle  = cnt_q == '0;
    cnt_d = (start && idle) ? (is_div ? MD_CNT_W'(DIV_CYCLES) : MD_CNT_W'(MULT_CYCLES))
          : idle ? cnt_q : cnt_q - 1'b1;
    err_d = err_q | (start & ~idle);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  assign busy = ~idle | start;
  assign cnt  = cnt_q;
  assign err  = err_q;
endmodule

// File: rtl/stall_ctrl.sv
// stall_ctrl: Tuse/Tnew data-hazard and mult/div busy stall decision for the 5-stage pipe
module stall_ctrl
  import cpu_defs::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES = DEF_DIV_CYCLES
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [REG_W-1:0]    D_rs,
  input  logic [REG_W-1:0]    D_rt,
  input  logic [T_W-1:0]      D_tuse_rs,
  input  logic [T_W-1:0]      D_tuse_rt,
  input  logic                D_is_md,
  input  logic [REG_W-1:0]    E_A3,
  input  logic [T_W-1:0]      E_tnew,
  input  logic [REG_W-1:0]    M_A3,
  input  logic [T_W-1:0]      M_tnew,
  input  logic                E_md_start,
  input  logic                E_md_is_div,
  output logic                stall,
  output logic                E_clr,
  output logic                md_busy,
  output logic [MD_CNT_W-1:0] md_cnt,
  output logic                md_err
);
  logic rs_haz, rt_haz;
  md_busy_counter #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) u_md (
    .clk(clk), .rst(rst), .start(E_md_start), .is_div(E_md_is_div),
    .busy(md_busy), .cnt(md_cnt), .err(md_err)
  );
  always_comb begin
    rs_haz = src_haz(D_rs, D_tuse_rs, E_A3, E_tnew) | src_haz(D_rs, D_tuse_rs, M_A3, M_tnew);
    rt_haz = src_haz(D_rt, D_tuse_rt, E_A3, E_tnew) | src_haz(D_rt, D_tuse_rt, M_A3, M_tnew);
    stall  = rs_haz | rt_haz | (D_is_md & md_busy);
    E_clr  = stall;
  end
endmodule

// File: tb/tb_stall_ctrl.sv
// tb_stall_ctrl: directed stimulus, deadline-based busy model checked every cycle
module tb_stall_ctrl;
  logic       clk = 0, rst = 1;
  logic [4:0] D_rs, D_rt, E_A3, M_A3;
  logic [1:0] D_tuse_rs, D_tuse_rt, E_tnew, M_tnew;
  logic       D_is_md, E_md_start, E_md_is_div;
  logic       stall, E_clr, md_busy, md_err;
  logic [3:0] md_cnt;
  int checks = 0, failures = 0;
  int cyc = 0, free_at = 0;
  bit m_err = 0;

  stall_ctrl dut (
    .clk(clk), .rst(rst), .D_rs(D_rs), .D_rt(D_rt), .D_tuse_rs(D_tuse_rs),
    .D_tuse_rt(D_tuse_rt), .D_is_md(D_is_md), .E_A3(E_A3), .E_tnew(E_tnew),
    .M_A3(M_A3), .M_tnew(M_tnew), .E_md_start(E_md_start), .E_md_is_div(E_md_is_div),
    .stall(stall), .E_clr(E_clr), .md_busy(md_busy), .md_cnt(md_cnt), .md_err(md_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d at %0t", n, a, e, $time);
    end
  endtask

  function automatic bit dep(int src, int tuse, int dst, int tnew);
    return src != 0 && src == dst && tnew > tuse;
  endfunction

  // The unit is free from cycle free_at on; an issue at cycle c keeps it busy through c+N.
  always @(posedge clk or posedge rst)
    if (rst) begin
      free_at = 0;
      m_err = 0;
    end else begin
      if (E_md_start) begin
        if (free_at > cyc) m_err = 1;
        else free_at = cyc + 1 + (E_md_is_div ? 10 : 5);
      end
      cyc++;
    end

  always @(negedge clk) begin
    int  e_cnt;
    bit  e_busy, e_stall;
    e_cnt   = (!rst && free_at > cyc) ? free_at - cyc : 0;
    e_busy  = e_cnt != 0 || E_md_start;
    e_stall = dep(D_rs, D_tuse_rs, E_A3, E_tnew) || dep(D_rs, D_tuse_rs, M_A3, M_tnew) ||
              dep(D_rt, D_tuse_rt, E_A3, E_tnew) || dep(D_rt, D_tuse_rt, M_A3, M_tnew) ||
              (D_is_md && e_busy);
    chk("m_cnt", md_cnt, e_cnt);
    chk("m_busy", md_busy, e_busy);
    chk("m_err", md_err, m_err && !rst);
    chk("m_stall", stall, e_stall);
    chk("m_eclr", E_clr, e_stall);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    D_rs = 0; D_rt = 0; D_tuse_rs = 3; D_tuse_rt = 3; D_is_md = 0;
    E_A3 = 0; E_tnew = 0; M_A3 = 0; M_tnew = 0; E_md_start = 0; E_md_is_div = 0;
  endtask

  initial begin
    idle();
    #1;
    chk("rst_cnt", md_cnt, 0);
    chk("rst_stall", stall, 0);
    tick(); tick();
    rst = 0;
    tick();
    E_A3 = 1; E_tnew = 2; D_rs = 1; D_tuse_rs = 1; #1;
    chk("lw_use_stall", stall, 1);
    chk("lw_use_eclr", E_clr, 1);
    tick();
    E_tnew = 1; #1;
    chk("tnew_eq_tuse", stall, 0);
    tick();
    idle(); E_tnew = 2; D_tuse_rs = 0; #1;
    chk("zero_reg", stall, 0);
    tick();
    idle(); M_A3 = 2; M_tnew = 2; D_rt = 2; D_tuse_rt = 1; #1;
    chk("m_rt_stall", stall, 1);
    tick();
    idle(); D_is_md = 1; E_md_start = 1; #1;
    chk("mult_issue_stall", stall, 1);
    chk("mult_issue_cnt", md_cnt, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      E_md_start = 0; #1;
      chk("mult_cnt", md_cnt, 5 - i);
      chk("mult_stall", stall, 1);
    end
    tick(); #1;
    chk("mult_done_cnt", md_cnt, 0);
    chk("mult_done_stall", stall, 0);
    E_md_start = 1; E_md_is_div = 1;
    tick();
    E_md_start = 0; tick(); tick();
    E_md_start = 1; E_md_is_div = 0;
    tick();
    E_md_start = 0; #1;
    chk("div_overlap_cnt", md_cnt, 7);
    chk("div_err", md_err, 1);
    repeat (7) tick();
    #1;
    chk("div_drain_cnt", md_cnt, 0);
    chk("err_sticky", md_err, 1);
    E_md_start = 1; E_md_is_div = 1;
    tick();
    E_md_start = 0;
    repeat (3) tick();
    #1;
    chk("pre_rst_cnt", md_cnt, 7);
    rst = 1; #1;
    chk("async_rst_cnt", md_cnt, 0);
    chk("async_rst_stall", stall, 0);
    chk("async_rst_err", md_err, 0);
    tick();
    rst = 0;
    tick();
    idle(); M_A3 = 4; M_tnew = 1; D_rt = 4; D_tuse_rt = 0; D_is_md = 1; E_md_start = 1; #1;
    chk("both_haz", stall, 1);
    tick();
    E_md_start = 0;
    repeat (6) tick();
    D_is_md = 0; #1;
    chk("m_data_only", stall, 1);
    D_tuse_rt = 3; #1;
    chk("tuse_never", stall, 0);
    tick(); tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
